// File: rtl/axi4_lite_master.sv
// AXI4-Lite master: turns one command into one AXI-Lite read or write and returns one response.
// A per-transaction cycle budget abandons a stuck slave and reports 2'b11.
module axi4_lite_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              ARESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic              BVALID,
  output logic              BREADY,
  input  logic [1:0]        BRESP,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             aw_done_r;
  logic             w_done_r;
  logic             accept_s;
  logic             active_s;
  logic             expire_s;
  logic             aw_done_s;
  logic             w_done_s;
  logic             complete_s;

  assign accept_s  = (state_r == S_IDLE) && cmd_ready && cmd_valid;
  assign active_s  = (state_r != S_IDLE) && (state_r != S_RESP);
  // Expires on the edge where the counter would reach TIMEOUT.
  assign expire_s  = (TIMEOUT > 0) && (cnt_r >= CNT_LAST);
  assign aw_done_s = aw_done_r || (AWVALID && AWREADY);
  assign w_done_s  = w_done_r || (WVALID && WREADY);

  // Handshake that finishes the current AXI phase this cycle
  always_comb begin
    complete_s = 1'b0;
    case (state_r)
      S_WADDR: complete_s = aw_done_s && w_done_s;
      S_WRESP: complete_s = BVALID && BREADY;
      S_RADDR: complete_s = ARVALID && ARREADY;
      S_RDATA: complete_s = RVALID && RREADY;
      default: complete_s = 1'b0;
    endcase
  end

  // Per-transaction cycle counter, saturating at TIMEOUT
  always_ff @(posedge clk or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= '0;
    end else if (active_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Transaction FSM with registered command, AXI and response outputs
  always_ff @(posedge clk or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r   <= S_IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else if (active_s && !complete_s && expire_s) begin
      state_r   <= S_RESP;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      rsp_valid <= 1'b1;
      rsp_resp  <= RESP_TIMEOUT;
      rsp_rdata <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              AWADDR  <= cmd_addr;
              WDATA   <= cmd_wdata;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state_r <= S_WADDR;
            end else begin
              ARADDR  <= cmd_addr;
              ARVALID <= 1'b1;
              state_r <= S_RADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_WADDR: begin
          if (complete_s) begin
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            BREADY    <= 1'b1;
            state_r   <= S_WRESP;
          end else begin
            // AW and W retire independently; remember whichever finished first.
            if (AWVALID && AWREADY) begin
              AWVALID   <= 1'b0;
              aw_done_r <= 1'b1;
            end
            if (WVALID && WREADY) begin
              WVALID   <= 1'b0;
              w_done_r <= 1'b1;
            end
          end
        end
        S_WRESP: begin
          if (complete_s) begin
            BREADY    <= 1'b0;
            rsp_resp  <= BRESP;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state_r   <= S_RESP;
          end
        end
        S_RADDR: begin
          if (complete_s) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state_r <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (complete_s) begin
            RREADY    <= 1'b0;
            rsp_rdata <= RDATA;
            rsp_resp  <= RRESP;
            rsp_valid <= 1'b1;
            state_r   <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
          AWVALID   <= 1'b0;
          WVALID    <= 1'b0;
          BREADY    <= 1'b0;
          ARVALID   <= 1'b0;
          RREADY    <= 1'b0;
          aw_done_r <= 1'b0;
          w_done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Self-checking bench for axi4_lite_master: scripted AXI slave plus a response scoreboard.
module tb_axi4_lite_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef logic [DW+1:0] rsp_t;

  logic          clk;
  logic          ARESETN;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] AWADDR;
  logic          AWVALID;
  logic          AWREADY;
  logic [DW-1:0] WDATA;
  logic          WVALID;
  logic          WREADY;
  logic          BVALID;
  logic          BREADY;
  logic [1:0]    BRESP;
  logic [AW-1:0] ARADDR;
  logic          ARVALID;
  logic          ARREADY;
  logic          RVALID;
  logic          RREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;

  int   check_cnt = 0;
  int   fail_cnt  = 0;
  rsp_t exp_q[$];
  int   last_aw_hs;
  int   last_w_hs;
  int   ar_high;
  int   lat;

  logic [88:0] outs_s;
  assign outs_s = {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, AWADDR, AWVALID, WDATA,
                   WVALID, BREADY, ARADDR, ARVALID, RREADY};

  axi4_lite_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slave();
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
  endtask

  // One command end to end; the slave answers from the delays given, at negedges.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int aw_dly, input int w_dly, input int ar_dly,
                         input logic [1:0] bresp, input logic [DW-1:0] rdata_v,
                         input logic [1:0] rresp_v, input int hold,
                         input logic [DW-1:0] exp_rdata, input logic [1:0] exp_resp,
                         input int exp_lat);
    int   cyc = 0;
    int   acc_cyc = 0;
    int   aw_n = 0;
    int   w_n = 0;
    int   ar_n = 0;
    int   hold_n = 0;
    logic accepted = 1'b0;
    logic done = 1'b0;
    logic aw_hs = 1'b0;
    logic w_hs = 1'b0;
    rsp_t held = '0;
    rsp_t exp_v;
    lat = -1; last_aw_hs = -1; last_w_hs = -1; ar_high = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    while (!done && cyc < 64) begin
      if (!accepted && cmd_valid && cmd_ready) begin
        exp_q.push_back({exp_rdata, exp_resp});
        acc_cyc  = cyc;
        accepted = 1'b1;
      end else if (accepted) begin
        cmd_valid = 1'b0;
      end
      clear_slave();
      if (aw_hs) chk("awvalid_drop", 128'(AWVALID), 128'(0));
      if (w_hs) chk("wvalid_drop", 128'(WVALID), 128'(0));
      aw_hs = 1'b0; w_hs = 1'b0;
      if (AWVALID) begin
        if (aw_n >= aw_dly) begin
          AWREADY = 1'b1; aw_hs = 1'b1; last_aw_hs = cyc;
          chk("awaddr", 128'(AWADDR), 128'(addr));
        end
        aw_n++;
      end
      if (WVALID) begin
        if (w_n >= w_dly) begin
          WREADY = 1'b1; w_hs = 1'b1; last_w_hs = cyc;
          chk("wdata", 128'(WDATA), 128'(wdata));
        end
        w_n++;
      end
      if (BREADY) begin
        BVALID = 1'b1; BRESP = bresp;
      end
      if (ARVALID) begin
        ar_high++;
        if (ar_n >= ar_dly) begin
          ARREADY = 1'b1;
          chk("araddr", 128'(ARADDR), 128'(addr));
        end
        ar_n++;
      end
      if (RREADY) begin
        RVALID = 1'b1; RDATA = rdata_v; RRESP = rresp_v;
      end
      if (rsp_valid) begin
        if (lat < 0) begin
          lat  = cyc - acc_cyc;
          held = {rsp_rdata, rsp_resp};
        end else begin
          chk("rsp_stable", 128'({rsp_rdata, rsp_resp}), 128'(held));
        end
        chk("cmd_ready_in_resp", 128'(cmd_ready), 128'(0));
        if (hold_n >= hold) begin
          rsp_ready = 1'b1;
          done      = 1'b1;
          chk("sb_size", 128'(exp_q.size()), 128'(1));
          if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            chk("rsp", 128'({rsp_rdata, rsp_resp}), 128'(exp_v));
          end
        end
        hold_n++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("txn_done", 128'(done), 128'(1));
    if (exp_lat >= 0) chk("latency", 128'(lat), 128'(exp_lat));
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    clear_slave();
    chk("rsp_valid_clear", 128'(rsp_valid), 128'(0));
    chk("cmd_ready_back", 128'(cmd_ready), 128'(1));
  endtask

  logic          r_wr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;

  initial begin
    ARESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    clear_slave();
    repeat (2) @(negedge clk);
    chk("reset_outputs", 128'(outs_s), 128'(0));
    #1 ARESETN = 1'b1;
    chk("cmd_ready_at_release", 128'(cmd_ready), 128'(0));
    @(negedge clk);
    chk("cmd_ready_after_release", 128'(cmd_ready), 128'(1));

    // Basic write, then write with W finishing two cycles ahead of AW.
    run_txn(1'b1, 8'h08, 32'hDEADBEEF, 0, 0, 0, 2'b00, 32'h0, 2'b00, 0, 32'h0, 2'b00, 3);
    run_txn(1'b1, 8'h0C, 32'hCAFE0001, 2, 0, 0, 2'b01, 32'h0, 2'b00, 0, 32'h0, 2'b01, 5);
    chk("w_before_aw", 128'(last_aw_hs - last_w_hs), 128'(2));

    // Reads: plain, held response, timeout, and handshakes on the expiry edge.
    run_txn(1'b0, 8'h10, 32'h0, 0, 0, 0, 2'b00, 32'h12345678, 2'b10, 0, 32'h12345678, 2'b10, 3);
    run_txn(1'b0, 8'h14, 32'h0, 0, 0, 0, 2'b00, 32'hA5A55A5A, 2'b00, 5, 32'hA5A55A5A, 2'b00, 3);
    run_txn(1'b0, 8'h18, 32'h0, 0, 0, 100, 2'b00, 32'h11111111, 2'b00, 0, 32'h0, 2'b11, 5);
    chk("timeout_arvalid_cycles", 128'(ar_high), 128'(TO));
    run_txn(1'b0, 8'h1C, 32'h0, 0, 0, 3, 2'b00, 32'h0BADF00D, 2'b01, 0, 32'h0BADF00D, 2'b01, 6);
    chk("prio_arvalid_cycles", 128'(ar_high), 128'(4));
    run_txn(1'b1, 8'h24, 32'h87654321, 3, 3, 0, 2'b10, 32'h0, 2'b00, 0, 32'h0, 2'b10, 6);

    // Stray BVALID/RVALID while idle must not produce a response.
    @(negedge clk);
    BVALID = 1'b1; RVALID = 1'b1; RDATA = 32'hBAD0BAD0; RRESP = 2'b01;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ignore_rsp", 128'(rsp_valid), 128'(0));
      chk("idle_cmd_ready", 128'(cmd_ready), 128'(1));
    end
    clear_slave();

    for (int i = 0; i < 6; i++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = 8'($urandom_range(0, 255));
      r_data = $urandom;
      r_resp = 2'($urandom_range(0, 2));
      if (r_wr)
        run_txn(1'b1, r_addr, r_data, $urandom_range(0, 1), $urandom_range(0, 1), 0,
                r_resp, 32'h0, 2'b00, $urandom_range(0, 2), 32'h0, r_resp, -1);
      else
        run_txn(1'b0, r_addr, 32'h0, 0, 0, $urandom_range(0, 2),
                2'b00, r_data, r_resp, $urandom_range(0, 2), r_data, r_resp, -1);
    end

    // Reset while waiting for the write response.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 32'h55AA55AA;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_awvalid", 128'(AWVALID), 128'(1));
    AWREADY = 1'b1; WREADY = 1'b1;
    @(negedge clk);
    AWREADY = 1'b0; WREADY = 1'b0;
    chk("rst_bready", 128'(BREADY), 128'(1));
    #2 ARESETN = 1'b0;
    #1 chk("rst_async_outputs", 128'(outs_s), 128'(0));
    @(negedge clk);
    chk("rst_hold_outputs", 128'(outs_s), 128'(0));
    #1 ARESETN = 1'b1;
    chk("rst_release_cmd_ready", 128'(cmd_ready), 128'(0));
    @(negedge clk);
    chk("rst_cmd_ready_rise", 128'(cmd_ready), 128'(1));
    chk("rst_no_rsp", 128'(rsp_valid), 128'(0));
    @(negedge clk);
    chk("rst_no_rsp_later", 128'(rsp_valid), 128'(0));
    chk("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
